// File: rtl/pic_instr_sequencer_pkg.sv
// Shared definitions for the PIC16-style instruction sequencer and its ALU.
// Contents:
//   alu_op_e         - ALU operation codes driven on alu_op
//   *_MASK / *_PAT   - 14-bit opcode match patterns for the decoded subset
//   instr_class_e    - decoded instruction class used by the sequencer
//   decode_instr()   - maps a raw instruction word onto instr_class_e
package pic_instr_sequencer_pkg;

    // ALU operation codes; the ALU decodes the same enum.
    typedef enum logic [3:0] {
        ALU_NOP     = 4'h0,
        ALU_PASSLF  = 4'h1,
        ALU_BITTEST = 4'h2,
        ALU_INC     = 4'h3,
        ALU_DEC     = 4'h4
    } alu_op_e;

    // Standard PIC16 14-bit encodings (mask selects the fixed opcode bits).
    localparam logic [13:0] NOP_MASK    = 14'h3F9F;
    localparam logic [13:0] NOP_PAT     = 14'h0000;
    localparam logic [13:0] RETURN_PAT  = 14'h0008;
    localparam logic [13:0] LIT_MASK    = 14'h3C00;
    localparam logic [13:0] MOVLW_PAT   = 14'h3000;
    localparam logic [13:0] RETLW_PAT   = 14'h3400;
    localparam logic [13:0] BR_MASK     = 14'h3800;
    localparam logic [13:0] CALL_PAT    = 14'h2000;
    localparam logic [13:0] GOTO_PAT    = 14'h2800;
    localparam logic [13:0] BIT_MASK    = 14'h3C00;
    localparam logic [13:0] BTFSC_PAT   = 14'h1800;
    localparam logic [13:0] BTFSS_PAT   = 14'h1C00;
    localparam logic [13:0] BYTE_MASK   = 14'h3F00;
    localparam logic [13:0] DECFSZ_PAT  = 14'h0B00;
    localparam logic [13:0] INCFSZ_PAT  = 14'h0F00;

    // Bit position of the destination select (d) in byte-oriented ops.
    localparam int D_BIT = 7;

    typedef enum logic [3:0] {
        IC_NOP    = 4'd0,
        IC_MOVLW  = 4'd1,
        IC_RETLW  = 4'd2,
        IC_GOTO   = 4'd3,
        IC_CALL   = 4'd4,
        IC_RETURN = 4'd5,
        IC_BTFSC  = 4'd6,
        IC_BTFSS  = 4'd7,
        IC_DECFSZ = 4'd8,
        IC_INCFSZ = 4'd9
    } instr_class_e;

    // Anything outside the supported subset executes as a NOP.
    function automatic instr_class_e decode_instr(input logic [13:0] instr);
        instr_class_e cls;
        if ((instr & NOP_MASK) == NOP_PAT) begin
            cls = IC_NOP;
        end else if (instr == RETURN_PAT) begin
            cls = IC_RETURN;
        end else if ((instr & LIT_MASK) == MOVLW_PAT) begin
            cls = IC_MOVLW;
        end else if ((instr & LIT_MASK) == RETLW_PAT) begin
            cls = IC_RETLW;
        end else if ((instr & BR_MASK) == CALL_PAT) begin
            cls = IC_CALL;
        end else if ((instr & BR_MASK) == GOTO_PAT) begin
            cls = IC_GOTO;
        end else if ((instr & BIT_MASK) == BTFSC_PAT) begin
            cls = IC_BTFSC;
        end else if ((instr & BIT_MASK) == BTFSS_PAT) begin
            cls = IC_BTFSS;
        end else if ((instr & BYTE_MASK) == DECFSZ_PAT) begin
            cls = IC_DECFSZ;
        end else if ((instr & BYTE_MASK) == INCFSZ_PAT) begin
            cls = IC_INCFSZ;
        end else begin
            cls = IC_NOP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pic_instr_sequencer_if.sv
// Bus between the instruction sequencer and the core datapath.
// master (sequencer): reads hold, instr_current, skip_taken;
//                     drives ALU/W strobes, fetch strobes, pc, fetch_addr,
//                     q_phase, in_flush and the stack_ovf/stack_unf pulses.
// slave (datapath):   the mirror image.
interface pic_instr_sequencer_if
    import pic_instr_sequencer_pkg::*;
#(
    parameter int PC_W     = 13,
    parameter int Q_PHASES = 4
);
    localparam int QW = $clog2(Q_PHASES);

    logic            hold;
    logic [13:0]     instr_current;
    logic            skip_taken;
    logic            alu_sel_l;
    alu_op_e         alu_op;
    logic            alu_status_wr_en;
    logic            w_reg_wr_en;
    logic            instr_rd_en;
    logic            instr_flush;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] fetch_addr;
    logic [QW-1:0]   q_phase;
    logic            in_flush;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        input  hold, instr_current, skip_taken,
        output alu_sel_l, alu_op, alu_status_wr_en, w_reg_wr_en,
               instr_rd_en, instr_flush, pc, fetch_addr, q_phase,
               in_flush, stack_ovf, stack_unf
    );

    modport slave (
        output hold, instr_current, skip_taken,
        input  alu_sel_l, alu_op, alu_status_wr_en, w_reg_wr_en,
               instr_rd_en, instr_flush, pc, fetch_addr, q_phase,
               in_flush, stack_ovf, stack_unf
    );

endinterface

// File: rtl/pic_instr_sequencer_return_stack.sv
// Circular hardware return stack.
// Ports: clk, rst (sync, active-high), push, pop, din (return address in),
//        dout (top-of-stack, combinational), ovf (push while full),
//        unf (pop while empty).
// The pointer always wraps; the count saturates at STACK_DEPTH so that a
// push onto a full stack silently overwrites the oldest entry and a pop
// from an empty stack still returns whatever sits below the pointer.
module return_stack #(
    parameter int PC_W        = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            ovf,
    output logic            unf
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(STACK_DEPTH);

    logic [PC_W-1:0] mem_r [STACK_DEPTH];
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   ptr_dec_s;
    logic [CW-1:0]   count_r;
    logic            full_s;
    logic            empty_s;

    assign ptr_dec_s = ptr_r - PW'(1);
    assign full_s    = (count_r == FULL_COUNT);
    assign empty_s   = (count_r == CW'(0));
    assign dout      = mem_r[ptr_dec_s];
    assign ovf       = push & full_s;
    assign unf       = pop & ~push & empty_s;

    // Pointer and occupancy count; push takes priority if both are raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (push) begin
            ptr_r   <= ptr_r + PW'(1);
            count_r <= full_s ? count_r : count_r + CW'(1);
        end else if (pop) begin
            ptr_r   <= ptr_dec_s;
            count_r <= empty_s ? count_r : count_r - CW'(1);
        end else begin
            ptr_r   <= ptr_r;
            count_r <= count_r;
        end
    end

    // Entry storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_r[ptr_r] <= din;
        end
    end

endmodule

// File: rtl/pic_instr_sequencer.sv
// PIC16-style instruction sequencer.
// Ports: clk, rst (sync, active-high), bus (pic_instr_sequencer_if.master).
// Each instruction takes Q_PHASES clocks. Phase 1 drives the ALU/W strobes
// for the instruction in the external instruction register; the last phase
// either fetches sequentially (pc+1) or redirects (GOTO/CALL/RETURN/RETLW/
// taken skip), in which case the instruction register is flushed and one
// forced-NOP cycle follows whose last phase fetches from the new pc.
module pic_instr_sequencer
    import pic_instr_sequencer_pkg::*;
#(
    parameter int              PC_W         = 13,
    parameter int              STACK_DEPTH  = 8,
    parameter int              Q_PHASES     = 4,
    parameter logic [PC_W-1:0] RESET_VECTOR = {PC_W{1'b0}}
) (
    input logic                  clk,
    input logic                  rst,
    pic_instr_sequencer_if.master bus
);
    localparam int QW = $clog2(Q_PHASES);
    localparam logic [QW-1:0] LAST_PHASE = QW'(Q_PHASES - 1);
    localparam logic [QW-1:0] ALU_PHASE  = QW'(1);

    logic [QW-1:0]   q_phase_r;
    logic [QW-1:0]   q_phase_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic            in_flush_r;
    logic            in_flush_nxt_s;

    logic            run_s;
    logic            last_s;
    logic            alu_s;
    instr_class_e    class_s;
    logic [PC_W-1:0] pc_plus1_s;
    logic [PC_W-1:0] pc_plus2_s;
    logic [PC_W-1:0] jump_tgt_s;
    logic            push_s;
    logic            pop_s;
    logic            redirect_s;
    logic            seq_fetch_s;
    logic [PC_W-1:0] pop_data_s;
    logic            ovf_s;
    logic            unf_s;

    // Reset and hold both silence every strobe and freeze all state.
    assign run_s      = ~bus.hold & ~rst;
    assign last_s     = (q_phase_r == LAST_PHASE);
    assign alu_s      = (q_phase_r == ALU_PHASE);
    assign class_s    = decode_instr(bus.instr_current);
    assign pc_plus1_s = pc_r + PC_W'(1);
    assign pc_plus2_s = pc_r + PC_W'(2);
    assign jump_tgt_s = PC_W'(bus.instr_current[10:0]);

    return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s),
        .din  (pc_plus1_s),
        .dout (pop_data_s),
        .ovf  (ovf_s),
        .unf  (unf_s)
    );

    // State register: phase counter, program counter, forced-NOP flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_phase_r  <= {QW{1'b0}};
            pc_r       <= RESET_VECTOR;
            in_flush_r <= 1'b0;
        end else begin
            q_phase_r  <= q_phase_nxt_s;
            pc_r       <= pc_nxt_s;
            in_flush_r <= in_flush_nxt_s;
        end
    end

    // Next-state logic: phase advance and last-phase pc/stack decisions.
    always_comb begin
        q_phase_nxt_s  = q_phase_r;
        pc_nxt_s       = pc_r;
        in_flush_nxt_s = in_flush_r;
        push_s         = 1'b0;
        pop_s          = 1'b0;
        redirect_s     = 1'b0;
        seq_fetch_s    = 1'b0;
        if (run_s) begin
            q_phase_nxt_s = last_s ? {QW{1'b0}} : q_phase_r + QW'(1);
            if (last_s && in_flush_r) begin
                // End of forced NOP: refill from the already-updated pc.
                seq_fetch_s    = 1'b1;
                in_flush_nxt_s = 1'b0;
            end else if (last_s) begin
                case (class_s)
                    IC_GOTO: begin
                        redirect_s     = 1'b1;
                        pc_nxt_s       = jump_tgt_s;
                        in_flush_nxt_s = 1'b1;
                    end
                    IC_CALL: begin
                        redirect_s     = 1'b1;
                        push_s         = 1'b1;
                        pc_nxt_s       = jump_tgt_s;
                        in_flush_nxt_s = 1'b1;
                    end
                    IC_RETURN, IC_RETLW: begin
                        redirect_s     = 1'b1;
                        pop_s          = 1'b1;
                        pc_nxt_s       = pop_data_s;
                        in_flush_nxt_s = 1'b1;
                    end
                    IC_BTFSC, IC_BTFSS, IC_DECFSZ, IC_INCFSZ: begin
                        if (bus.skip_taken) begin
                            redirect_s     = 1'b1;
                            pc_nxt_s       = pc_plus2_s;
                            in_flush_nxt_s = 1'b1;
                        end else begin
                            seq_fetch_s = 1'b1;
                            pc_nxt_s    = pc_plus1_s;
                        end
                    end
                    default: begin
                        seq_fetch_s = 1'b1;
                        pc_nxt_s    = pc_plus1_s;
                    end
                endcase
            end else begin
                pc_nxt_s = pc_r;
            end
        end else begin
            q_phase_nxt_s = q_phase_r;
        end
    end

    // Output logic: ALU-phase strobes and last-phase fetch/flush strobes.
    always_comb begin
        bus.alu_sel_l        = 1'b0;
        bus.alu_op           = ALU_NOP;
        bus.alu_status_wr_en = 1'b0;   // none of the decoded subset updates STATUS
        bus.w_reg_wr_en      = 1'b0;
        bus.instr_rd_en      = seq_fetch_s;
        bus.instr_flush      = redirect_s;
        bus.fetch_addr       = in_flush_r ? pc_r : pc_plus1_s;
        if (run_s && alu_s && !in_flush_r) begin
            case (class_s)
                IC_MOVLW, IC_RETLW: begin
                    bus.alu_sel_l   = 1'b1;
                    bus.alu_op      = ALU_PASSLF;
                    bus.w_reg_wr_en = 1'b1;
                end
                IC_BTFSC, IC_BTFSS: begin
                    bus.alu_op = ALU_BITTEST;
                end
                IC_DECFSZ: begin
                    bus.alu_op      = ALU_DEC;
                    bus.w_reg_wr_en = ~bus.instr_current[D_BIT];
                end
                IC_INCFSZ: begin
                    bus.alu_op      = ALU_INC;
                    bus.w_reg_wr_en = ~bus.instr_current[D_BIT];
                end
                default: begin
                    bus.alu_op = ALU_NOP;
                end
            endcase
        end else begin
            bus.alu_op = ALU_NOP;
        end
    end

    assign bus.pc        = pc_r;
    assign bus.q_phase   = q_phase_r;
    assign bus.in_flush  = in_flush_r;
    assign bus.stack_ovf = ovf_s;
    assign bus.stack_unf = unf_s;

endmodule

// File: tb/tb_pic_instr_sequencer.sv
// Scoreboard bench for pic_instr_sequencer: stimulus pushes the expected
// strobe events, a negedge monitor pops one whenever any strobe is active.
module tb_pic_instr_sequencer;
    import pic_instr_sequencer_pkg::*;

    localparam int PC_W  = 13;
    localparam int DEPTH = 8;
    localparam int QP    = 4;
    localparam int QW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pic_instr_sequencer_if #(.PC_W(PC_W), .Q_PHASES(QP)) bus ();

    pic_instr_sequencer #(
        .PC_W         (PC_W),
        .STACK_DEPTH  (DEPTH),
        .Q_PHASES     (QP),
        .RESET_VECTOR (13'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [QW-1:0]   q;
        logic            inf;
        logic            sel;
        logic [3:0]      op;
        logic            w;
        logic            st;
        logic            rd;
        logic            fl;
        logic [PC_W-1:0] fa;
        logic            ovf;
        logic            unf;
    } ev_t;

    ev_t exp_q[$];
    ev_t act_ev;
    ev_t exp_ev;
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic string fmt(input ev_t e);
        return $sformatf("pc=%h q=%0d inf=%b sel=%b op=%h w=%b st=%b rd=%b fl=%b fa=%h ovf=%b unf=%b",
                         e.pc, e.q, e.inf, e.sel, e.op, e.w, e.st, e.rd, e.fl, e.fa, e.ovf, e.unf);
    endfunction

    task automatic push_ev(input logic [PC_W-1:0] pc, input logic [QW-1:0] q, input logic inf,
                           input logic sel, input alu_op_e op, input logic w, input logic rd,
                           input logic fl, input logic [PC_W-1:0] fa, input logic ovf,
                           input logic unf);
        ev_t e;
        e.pc = pc; e.q = q; e.inf = inf; e.sel = sel; e.op = op; e.w = w; e.st = 1'b0;
        e.rd = rd; e.fl = fl; e.fa = rd ? fa : 13'h0000; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
    endtask

    // Sequential fetch at the last phase: fetch_addr = pc+1.
    task automatic exp_fetch(input logic [PC_W-1:0] pc);
        logic [PC_W-1:0] nxt;
        nxt = pc + 13'd1;
        push_ev(pc, 2'd3, 1'b0, 1'b0, ALU_NOP, 1'b0, 1'b1, 1'b0, nxt, 1'b0, 1'b0);
    endtask

    task automatic exp_redirect(input logic [PC_W-1:0] pc, input logic ovf, input logic unf);
        push_ev(pc, 2'd3, 1'b0, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b1, 13'h0000, ovf, unf);
    endtask

    task automatic exp_flushfetch(input logic [PC_W-1:0] pc);
        push_ev(pc, 2'd3, 1'b1, 1'b0, ALU_NOP, 1'b0, 1'b1, 1'b0, pc, 1'b0, 1'b0);
    endtask

    task automatic exp_alu(input logic [PC_W-1:0] pc, input logic sel, input alu_op_e op,
                           input logic w);
        push_ev(pc, 2'd1, 1'b0, sel, op, w, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [13:0] instr, input logic skip);
        bus.instr_current = instr;
        bus.skip_taken    = skip;
        repeat (QP) tick();
    endtask

    // Forced-NOP cycle with a MOVLW left on the bus that must be ignored.
    task automatic run_flush();
        bus.instr_current = 14'h30FF;
        bus.skip_taken    = 1'b1;
        repeat (QP) tick();
    endtask

    // Monitor: any active strobe is an event that must match the queue head.
    always @(negedge clk) begin
        if (bus.instr_rd_en || bus.instr_flush || bus.w_reg_wr_en || bus.alu_sel_l ||
            bus.alu_status_wr_en || (bus.alu_op != ALU_NOP) || bus.stack_ovf || bus.stack_unf) begin
            act_ev.pc  = bus.pc;
            act_ev.q   = bus.q_phase;
            act_ev.inf = bus.in_flush;
            act_ev.sel = bus.alu_sel_l;
            act_ev.op  = bus.alu_op;
            act_ev.w   = bus.w_reg_wr_en;
            act_ev.st  = bus.alu_status_wr_en;
            act_ev.rd  = bus.instr_rd_en;
            act_ev.fl  = bus.instr_flush;
            act_ev.fa  = bus.instr_rd_en ? bus.fetch_addr : 13'h0000;
            act_ev.ovf = bus.stack_ovf;
            act_ev.unf = bus.stack_unf;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event got %s want no event", fmt(act_ev));
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    n_fail++;
                    $display("FAIL event got %s want %s", fmt(act_ev), fmt(exp_ev));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PC_W-1:0] p;
        logic [PC_W-1:0] tgt;
        bus.hold          = 1'b0;
        bus.instr_current = 14'h0000;
        bus.skip_taken    = 1'b0;
        rst               = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_q_phase", 32'(bus.q_phase), 32'd0);
        check("reset_pc", 32'(bus.pc), 32'h0);
        check("reset_in_flush", 32'(bus.in_flush), 32'd0);

        // NOP stream: pc 1, 2, 3 after clocks 4, 8, 12.
        for (int i = 0; i < 3; i++) begin
            exp_fetch(13'(i));
            run_instr(14'h0000, 1'b0);
            check("nop_pc", 32'(bus.pc), 32'(i + 1));
        end

        // MOVLW 0x55 at pc 3.
        exp_alu(13'h003, 1'b1, ALU_PASSLF, 1'b1);
        exp_fetch(13'h003);
        run_instr(14'h3055, 1'b0);
        check("movlw_pc", 32'(bus.pc), 32'h4);

        exp_fetch(13'h004);
        run_instr(14'h0000, 1'b0);

        // GOTO 0x2ABC at pc 5 -> 0x2BC, then forced NOP fetching 0x2BC.
        exp_redirect(13'h005, 1'b0, 1'b0);
        run_instr(14'h2ABC, 1'b0);
        check("goto_pc", 32'(bus.pc), 32'h2BC);
        check("goto_in_flush", 32'(bus.in_flush), 32'd1);
        exp_flushfetch(13'h2BC);
        run_flush();
        check("flush_cleared", 32'(bus.in_flush), 32'd0);
        check("flush_pc", 32'(bus.pc), 32'h2BC);

        // DECFSZ d=0 not taken, INCFSZ d=1 taken, BTFSC not taken, unknown op.
        exp_alu(13'h2BC, 1'b0, ALU_DEC, 1'b1);
        exp_fetch(13'h2BC);
        run_instr(14'h0B20, 1'b0);
        exp_alu(13'h2BD, 1'b0, ALU_INC, 1'b0);
        exp_redirect(13'h2BD, 1'b0, 1'b0);
        run_instr(14'h0FA0, 1'b1);
        check("incfsz_skip_pc", 32'(bus.pc), 32'h2BF);
        exp_flushfetch(13'h2BF);
        run_flush();
        exp_alu(13'h2BF, 1'b0, ALU_BITTEST, 1'b0);
        exp_fetch(13'h2BF);
        run_instr(14'h1805, 1'b0);
        exp_fetch(13'h2C0);
        run_instr(14'h0064, 1'b0);
        check("undef_pc", 32'(bus.pc), 32'h2C1);

        // Nine nested CALLs to 0x110, 0x120 .. 0x190; the 9th overflows.
        p = 13'h2C1;
        for (int i = 1; i <= 9; i++) begin
            tgt = 13'(32'h100 + i * 16);
            exp_redirect(p, (i == 9), 1'b0);
            run_instr(14'h2000 | 14'(tgt), 1'b0);
            check("call_pc", 32'(bus.pc), 32'(tgt));
            exp_flushfetch(tgt);
            run_flush();
            p = tgt;
        end

        // First return is RETLW: pops 0x181 (pushed by the CALL at 0x180).
        exp_alu(13'h190, 1'b1, ALU_PASSLF, 1'b1);
        exp_redirect(13'h190, 1'b0, 1'b0);
        run_instr(14'h34AA, 1'b0);
        check("retlw_pc", 32'(bus.pc), 32'h181);
        exp_flushfetch(13'h181);
        run_flush();
        p = 13'h181;
        for (int j = 2; j <= 8; j++) begin
            tgt = 13'(32'h100 + (9 - j) * 16 + 1);
            exp_redirect(p, 1'b0, 1'b0);
            run_instr(14'h0008, 1'b0);
            check("return_pc", 32'(bus.pc), 32'(tgt));
            exp_flushfetch(tgt);
            run_flush();
            p = tgt;
        end
        // 9th RETURN: empty, underflow, wrapped pointer holds 0x181.
        exp_redirect(13'h111, 1'b0, 1'b1);
        run_instr(14'h0008, 1'b0);
        check("underflow_pc", 32'(bus.pc), 32'h181);
        exp_flushfetch(13'h181);
        run_flush();

        // Walk to the top of the address space.
        p = 13'h181;
        while (p != 13'h1FFF) begin
            exp_fetch(p);
            run_instr(14'h0000, 1'b0);
            p = p + 13'd1;
        end
        check("walk_pc", 32'(bus.pc), 32'h1FFF);

        // BTFSS taken at 0x1FFF wraps to 0x0001.
        exp_alu(13'h1FFF, 1'b0, ALU_BITTEST, 1'b0);
        exp_redirect(13'h1FFF, 1'b0, 1'b0);
        run_instr(14'h1C83, 1'b1);
        check("wrap_pc", 32'(bus.pc), 32'h0001);
        check("wrap_in_flush", 32'(bus.in_flush), 32'd1);
        exp_flushfetch(13'h0001);
        run_flush();

        // CALL 0x050 at pc 1, held for 3 clocks in phase 2.
        exp_redirect(13'h001, 1'b0, 1'b0);
        bus.instr_current = 14'h2050;
        bus.skip_taken    = 1'b0;
        tick();
        tick();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q_phase", 32'(bus.q_phase), 32'd2);
            check("hold_pc", 32'(bus.pc), 32'h001);
        end
        bus.hold = 1'b0;
        tick();
        tick();
        check("resume_pc", 32'(bus.pc), 32'h050);
        check("resume_in_flush", 32'(bus.in_flush), 32'd1);
        bus.instr_current = 14'h30FF;
        tick();
        tick();
        // Reset mid-flush with hold also high: reset wins.
        bus.hold = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        bus.hold = 1'b0;
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_q_phase", 32'(bus.q_phase), 32'd0);
        check("rst_in_flush", 32'(bus.in_flush), 32'd0);

        // Stack count was cleared: RETURN underflows and reads stale entry 7.
        exp_redirect(13'h000, 1'b0, 1'b1);
        run_instr(14'h0008, 1'b0);
        check("rst_stack_pc", 32'(bus.pc), 32'h171);
        exp_flushfetch(13'h171);
        run_flush();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
